// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
// Shares one combinational ALU between two requesters. Requests are taken on
// valid/ready handshakes and granted round-robin while idle. The winner's operands
// and opcode are registered onto the ALU inputs. The ALU result is captured one
// cycle later and returned with the requester ID on a single response channel.
//
// Optional feature: define ALU_ARB_OPCHECK_EN to reject opcodes outside 0x0-0x8 and
// 0xD. A rejected request is answered directly with data 0 and err 1. It does not
// touch the ALU input registers.
//
// Ports:
//   clk_in, rst_n_in                  clock, asynchronous active-low reset
//   reqN_valid_in / reqN_ready_out    request handshake for requester N (0, 1)
//   reqN_op1_in, reqN_op2_in          requester N operands
//   reqN_opcode_in                    requester N ALU opcode
//   alu_op1_out, alu_op2_out          registered operands to the ALU
//   alu_opcode_out                    registered opcode to the ALU
//   alu_result_in                     combinational ALU result
//   rsp_valid_out / rsp_ready_in      response handshake
//   rsp_id_out, rsp_data_out          owner of the response and captured result
//   rsp_err_out                       illegal-opcode flag (0 unless the check is enabled)
//   busy_out                          not idle
module alu_share_arbiter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             req0_valid_in,
  output logic             req0_ready_out,
  input  logic [WIDTH-1:0] req0_op1_in,
  input  logic [WIDTH-1:0] req0_op2_in,
  input  logic [3:0]       req0_opcode_in,
  input  logic             req1_valid_in,
  output logic             req1_ready_out,
  input  logic [WIDTH-1:0] req1_op1_in,
  input  logic [WIDTH-1:0] req1_op2_in,
  input  logic [3:0]       req1_opcode_in,
  output logic [WIDTH-1:0] alu_op1_out,
  output logic [WIDTH-1:0] alu_op2_out,
  output logic [3:0]       alu_opcode_out,
  input  logic [WIDTH-1:0] alu_result_in,
  output logic             rsp_valid_out,
  input  logic             rsp_ready_in,
  output logic             rsp_id_out,
  output logic [WIDTH-1:0] rsp_data_out,
  output logic             rsp_err_out,
  output logic             busy_out
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StIssue = 2'd1;
  localparam logic [1:0] StResp  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic [WIDTH-1:0] alu_op1_q, alu_op1_d;
  logic [WIDTH-1:0] alu_op2_q, alu_op2_d;
  logic [3:0]       alu_opcode_q, alu_opcode_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic             rsp_err_q, rsp_err_d;

  logic             idle;
  logic             grant0, grant1, accept;
  logic [WIDTH-1:0] win_op1, win_op2;
  logic [3:0]       win_opcode;
  logic             illegal;

  assign idle = (state_q == StIdle);

  // On contention, the requester that was not granted last time wins.
  // Ready is gated by reset so that no handshake is advertised while in reset.
  assign grant0 = rst_n_in & idle & req0_valid_in & (~req1_valid_in | last_grant_q);
  assign grant1 = rst_n_in & idle & req1_valid_in & (~req0_valid_in | ~last_grant_q);
  assign accept = grant0 | grant1;

  assign win_op1    = grant1 ? req1_op1_in    : req0_op1_in;
  assign win_op2    = grant1 ? req1_op2_in    : req0_op2_in;
  assign win_opcode = grant1 ? req1_opcode_in : req0_opcode_in;

`ifdef ALU_ARB_OPCHECK_EN
  assign illegal = (win_opcode > 4'h8) && (win_opcode != 4'hD);
`else
  assign illegal = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    alu_op1_d    = alu_op1_q;
    alu_op2_d    = alu_op2_q;
    alu_opcode_d = alu_opcode_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_data_d   = rsp_data_q;
    rsp_err_d    = rsp_err_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          last_grant_d = grant1;
          rsp_id_d     = grant1;
          if (illegal) begin
            // Answer directly. The ALU inputs keep their last legal operation.
            rsp_data_d  = '0;
            rsp_err_d   = 1'b1;
            rsp_valid_d = 1'b1;
            state_d     = StResp;
          end else begin
            alu_op1_d    = win_op1;
            alu_op2_d    = win_op2;
            alu_opcode_d = win_opcode;
            state_d      = StIssue;
          end
        end
      end
      StIssue: begin
        rsp_data_d  = alu_result_in;
        rsp_err_d   = 1'b0;
        rsp_valid_d = 1'b1;
        state_d     = StResp;
      end
      StResp: begin
        if (rsp_ready_in) begin
          rsp_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
      alu_op1_q    <= '0;
      alu_op2_q    <= '0;
      alu_opcode_q <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_data_q   <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      alu_op1_q    <= alu_op1_d;
      alu_op2_q    <= alu_op2_d;
      alu_opcode_q <= alu_opcode_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_data_q   <= rsp_data_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  assign req0_ready_out = grant0;
  assign req1_ready_out = grant1;
  assign alu_op1_out    = alu_op1_q;
  assign alu_op2_out    = alu_op2_q;
  assign alu_opcode_out = alu_opcode_q;
  assign rsp_valid_out  = rsp_valid_q;
  assign rsp_id_out     = rsp_id_q;
  assign rsp_data_out   = rsp_data_q;
  assign rsp_err_out    = rsp_err_q;
  assign busy_out       = ~idle;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter. The bench acts as the ALU, drives directed
// and random transactions, and predicts each grant, result and latency at transaction
// level.
module tb_alu_share_arbiter;

  localparam int W = 32;
`ifdef ALU_ARB_OPCHECK_EN
  localparam bit OpCheck = 1'b1;
`else
  localparam bit OpCheck = 1'b0;
`endif

  logic         clk_in = 1'b0;
  logic         rst_n_in;
  logic         req0_valid_in, req0_ready_out;
  logic [W-1:0] req0_op1_in, req0_op2_in;
  logic [3:0]   req0_opcode_in;
  logic         req1_valid_in, req1_ready_out;
  logic [W-1:0] req1_op1_in, req1_op2_in;
  logic [3:0]   req1_opcode_in;
  logic [W-1:0] alu_op1_out, alu_op2_out;
  logic [3:0]   alu_opcode_out;
  logic [W-1:0] alu_result_in;
  logic         rsp_valid_out, rsp_ready_in, rsp_id_out, rsp_err_out, busy_out;
  logic [W-1:0] rsp_data_out;

  always #5 clk_in = ~clk_in;

  alu_share_arbiter #(.WIDTH(W)) dut (
    .clk_in         (clk_in),
    .rst_n_in       (rst_n_in),
    .req0_valid_in  (req0_valid_in),
    .req0_ready_out (req0_ready_out),
    .req0_op1_in    (req0_op1_in),
    .req0_op2_in    (req0_op2_in),
    .req0_opcode_in (req0_opcode_in),
    .req1_valid_in  (req1_valid_in),
    .req1_ready_out (req1_ready_out),
    .req1_op1_in    (req1_op1_in),
    .req1_op2_in    (req1_op2_in),
    .req1_opcode_in (req1_opcode_in),
    .alu_op1_out    (alu_op1_out),
    .alu_op2_out    (alu_op2_out),
    .alu_opcode_out (alu_opcode_out),
    .alu_result_in  (alu_result_in),
    .rsp_valid_out  (rsp_valid_out),
    .rsp_ready_in   (rsp_ready_in),
    .rsp_id_out     (rsp_id_out),
    .rsp_data_out   (rsp_data_out),
    .rsp_err_out    (rsp_err_out),
    .busy_out       (busy_out)
  );

  function automatic logic [W-1:0] alu_fn(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [3:0] op);
    case (op)
      4'h0: return a + b;
      4'h1: return a << b[4:0];
      4'h2: return {31'd0, $signed(a) < $signed(b)};
      4'h3: return {31'd0, a < b};
      4'h4: return a ^ b;
      4'h5: return a >> b[4:0];
      4'h6: return a | b;
      4'h7: return a & b;
      4'h8: return a - b;
      4'hD: return W'($signed(a) >>> b[4:0]);
      default: return '0;
    endcase
  endfunction

  // The bench is the ALU instance.
  always_comb alu_result_in = alu_fn(alu_op1_out, alu_op2_out, alu_opcode_out);

  int n_checks = 0;
  int n_fail   = 0;

  // Pending request of each requester, plus the model's view of arbitration and
  // of the last operation placed on the ALU inputs.
  logic         p_v [2];
  logic [W-1:0] p_a [2];
  logic [W-1:0] p_b [2];
  logic [3:0]   p_o [2];
  int           m_last;
  logic [W-1:0] m_a1, m_a2;
  logic [3:0]   m_ao;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    req0_valid_in  = p_v[0];
    req0_op1_in    = p_a[0];
    req0_op2_in    = p_b[0];
    req0_opcode_in = p_o[0];
    req1_valid_in  = p_v[1];
    req1_op1_in    = p_a[1];
    req1_op2_in    = p_b[1];
    req1_opcode_in = p_o[1];
  endtask

  task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [3:0] o);
    p_v[i] = 1'b1;
    p_a[i] = a;
    p_b[i] = b;
    p_o[i] = o;
  endtask

  task automatic model_reset();
    m_last = 1;
    m_a1   = '0;
    m_a2   = '0;
    m_ao   = '0;
  endtask

  // One full transaction starting at a negedge while idle. It ends at the negedge
  // where the block is idle again. The response is held for `stall` extra cycles.
  task automatic round(input int stall);
    int           w;
    logic [W-1:0] a, b, d;
    logic [3:0]   o;
    logic         bad;
    w = (p_v[0] && p_v[1]) ? (m_last == 1 ? 0 : 1) : (p_v[0] ? 0 : 1);
    drive();
    rsp_ready_in = (stall == 0);
    #1;
    chk("idle_ready0", req0_ready_out, W'(w == 0));
    chk("idle_ready1", req1_ready_out, W'(w == 1));
    chk("idle_busy", busy_out, 0);
    chk("idle_rsp_valid", rsp_valid_out, 0);
    a = p_a[w];
    b = p_b[w];
    o = p_o[w];
    p_v[w] = 1'b0;
    m_last = w;
    bad = OpCheck && (o > 4'h8) && (o != 4'hD);
    d = bad ? '0 : alu_fn(a, b, o);
    @(negedge clk_in);
    drive();
    #1;
    chk("busy_after_accept", busy_out, 1);
    chk("ready0_busy", req0_ready_out, 0);
    chk("ready1_busy", req1_ready_out, 0);
    if (!bad) begin
      chk("early_rsp_valid", rsp_valid_out, 0);
      m_a1 = a;
      m_a2 = b;
      m_ao = o;
      @(negedge clk_in);
    end
    chk("alu_op1", alu_op1_out, m_a1);
    chk("alu_op2", alu_op2_out, m_a2);
    chk("alu_opcode", alu_opcode_out, W'(m_ao));
    chk("rsp_valid", rsp_valid_out, 1);
    chk("rsp_data", rsp_data_out, d);
    chk("rsp_id", rsp_id_out, W'(w));
    chk("rsp_err", rsp_err_out, W'(bad));
    for (int k = 0; k < stall; k++) begin
      @(negedge clk_in);
      chk("stall_valid", rsp_valid_out, 1);
      chk("stall_data", rsp_data_out, d);
      chk("stall_id", rsp_id_out, W'(w));
      chk("stall_ready0", req0_ready_out, 0);
      chk("stall_ready1", req1_ready_out, 0);
      chk("stall_busy", busy_out, 1);
      if (k == stall - 1) rsp_ready_in = 1'b1;
    end
    @(negedge clk_in);
    chk("done_rsp_valid", rsp_valid_out, 0);
    chk("done_busy", busy_out, 0);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      p_v[i] = 1'b0;
      p_a[i] = '0;
      p_b[i] = '0;
      p_o[i] = '0;
    end
    model_reset();
    rst_n_in     = 1'b0;
    rsp_ready_in = 1'b0;
    drive();
    repeat (2) @(negedge clk_in);

    // Reset state, with both requesters already valid (contention stimulus).
    set_req(0, 32'd1, 32'd1, 4'h0);
    set_req(1, 32'd10, 32'd3, 4'h8);
    drive();
    #1;
    chk("rst_ready0", req0_ready_out, 0);
    chk("rst_ready1", req1_ready_out, 0);
    chk("rst_busy", busy_out, 0);
    chk("rst_rsp_valid", rsp_valid_out, 0);
    chk("rst_rsp_data", rsp_data_out, 0);
    chk("rst_rsp_id", rsp_id_out, 0);
    chk("rst_rsp_err", rsp_err_out, 0);
    chk("rst_alu_op1", alu_op1_out, 0);
    chk("rst_alu_opcode", alu_opcode_out, 0);
    @(negedge clk_in);
    rst_n_in = 1'b1;

    // Contention: req0 first, then req1, then req0 again on a fresh contention.
    round(0);
    chk("cont_first_data", rsp_data_out, 32'd2);
    chk("cont_first_id", rsp_id_out, 0);
    round(0);
    chk("cont_second_data", rsp_data_out, 32'd7);
    chk("cont_second_id", rsp_id_out, 1);
    set_req(0, 32'd4, 32'd4, 4'h7);
    set_req(1, 32'd4, 32'd1, 4'h1);
    round(0);
    chk("cont_again_id", rsp_id_out, 0);
    while (p_v[0] || p_v[1]) round(0);

    // Single request.
    set_req(0, 32'd5, 32'd7, 4'h0);
    round(0);
    chk("single_data", rsp_data_out, 32'd12);
    chk("single_id", rsp_id_out, 0);

    // Back-pressure for 5 cycles with the other requester still waiting.
    set_req(0, 32'hFFFF_FFF0, 32'd2, 4'hD);
    set_req(1, 32'h8000_0000, 32'd1, 4'h2);
    round(5);
    while (p_v[0] || p_v[1]) round(0);

    // Opcode 0xF: rejected when the check is enabled, issued otherwise.
    set_req(1, 32'd3, 32'd4, 4'hF);
    round(0);
    chk("opF_data", rsp_data_out, 0);
    chk("opF_err", rsp_err_out, W'(OpCheck));

    // Reset while in ISSUE: transaction dropped, arbitration restarts at req0.
    set_req(1, 32'd9, 32'd9, 4'h0);
    drive();
    @(negedge clk_in);
    set_req(0, 32'd20, 32'd22, 4'h4);
    drive();
    rst_n_in = 1'b0;
    #1;
    chk("midrst_busy", busy_out, 0);
    chk("midrst_rsp_valid", rsp_valid_out, 0);
    chk("midrst_ready0", req0_ready_out, 0);
    chk("midrst_ready1", req1_ready_out, 0);
    chk("midrst_alu_op1", alu_op1_out, 0);
    chk("midrst_alu_op2", alu_op2_out, 0);
    chk("midrst_rsp_data", rsp_data_out, 0);
    model_reset();
    @(negedge clk_in);
    rst_n_in = 1'b1;
    round(0);
    chk("postrst_id", rsp_id_out, 0);
    while (p_v[0] || p_v[1]) round(0);

    // Random traffic.
    for (int r = 0; r < 60; r++) begin
      for (int i = 0; i < 2; i++) begin
        if (!p_v[i] && ($urandom % 2 == 0)) begin
          if ($urandom % 4 == 0) set_req(i, W'($urandom % 16), W'($urandom % 40),
                                         4'($urandom % 16));
          else set_req(i, $urandom, $urandom, 4'($urandom % 16));
        end
      end
      if (!p_v[0] && !p_v[1]) set_req(int'($urandom % 2), $urandom, $urandom,
                                      4'($urandom % 16));
      round(int'($urandom % 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Sequencer/arbiter sharing one combinational ALU datapath (4-bit opcode; add, sll, slt, sltu, xor, srl, or, and, sub, sra) between two requesters. Accepts operand/opcode requests on valid/ready handshakes and grants the ALU round-robin. It drives the ALU inputs from registers, captures the ALU result one cycle later and returns it with the requester ID on a single response channel. It sits between the decode/issue stages and the ALU instance in the core datapath.

## Interface
- WIDTH, 32, operand/result width
- clk_in  input  1  clock, all state on rising edge
- rst_n_in  input  1  asynchronous active-low reset
- req0_valid_in  input  1  requester 0 has a request
- req0_ready_out  output  1  requester 0 request accepted this cycle
- req0_op1_in, req0_op2_in  input  WIDTH  requester 0 operands
- req0_opcode_in  input  4  requester 0 ALU opcode
- req1_valid_in, req1_ready_out, req1_op1_in, req1_op2_in, req1_opcode_in  same as requester 0, for requester 1
- alu_op1_out, alu_op2_out  output  WIDTH  registered operands to the ALU
- alu_opcode_out  output  4  registered opcode to the ALU
- alu_result_in  input  WIDTH  combinational ALU result
- rsp_valid_out  output  1  response available
- rsp_ready_in  input  1  consumer takes the response
- rsp_id_out  output  1  requester that owns the response
- rsp_data_out  output  WIDTH  captured result
- rsp_err_out  output  1  illegal opcode flag (see Configuration)
- busy_out  output  1  state is not IDLE

## Operation
- States: IDLE, ISSUE, RESP. Reset enters IDLE.
- IDLE arbitration:
  - If exactly one valid_in is high, that requester wins.
  - If both are high, the requester other than last_grant wins. last_grant resets to 1, so req0 wins first.
  - Only the winner's ready_out is high, combinationally, and only in IDLE.
- Accept (valid & ready):
  - Latch op1, op2, opcode into alu_*_out registers.
  - Latch the ID and set last_grant to the winner.
  - Go to ISSUE.
- ISSUE:
  - Capture alu_result_in into rsp_data_out, set rsp_err_out = 0, rsp_valid_out = 1.
  - Go to RESP.
- RESP:
  - Hold rsp_* stable until rsp_ready_in is high, then clear rsp_valid_out and go to IDLE.
  - No new accept in the same cycle as the response handshake.
- Unselected fields: alu_*_out hold their last value between operations.
- Requester obligation: hold op/opcode stable while valid is high and ready is low.
- Width rule: the result is passed through unmodified, WIDTH bits; no sign or width adjustment in this block.
- Reset behaviour:
  - All outputs go to 0 (ready_out is 0 during reset) and last_grant goes to 1.
  - A reset mid-operation drops the transaction; no response is produced.

## Timing
- Accept in cycle N; alu_*_out valid from N+1; rsp_valid_out high from N+2 (legal opcode).
- Minimum spacing between accepts is 3 cycles with rsp_ready_in held high. Each extra RESP stall cycle adds one cycle.
- ready_out depends only on state, valid inputs and last_grant. There is no combinational path from rsp_ready_in to ready_out.

## Configuration
- ALU_ARB_OPCHECK_EN defined:
  - Legal opcodes are 0x0–0x8 and 0xD.
  - An accepted request with any other opcode skips ISSUE and goes directly to RESP the next cycle (rsp_valid_out high at N+1).
  - That response has rsp_data_out = 0 and rsp_err_out = 1.
  - alu_*_out are not updated for the rejected request.
- ALU_ARB_OPCHECK_EN undefined:
  - All opcodes are issued through ISSUE.
  - rsp_err_out is tied 0 and rsp_data_out is whatever the ALU returns.

## Test plan
- Single request: req0 op1=5, op2=7, opcode=0x0, rsp_ready_in=1 → rsp_valid_out at N+2, rsp_data_out=12, rsp_id_out=0, rsp_err_out=0.
- Contention: both valid from reset, req1 sub 10-3, req0 add 1+1 → req0 served first (data 2, id 0), then req1 (data 7, id 1). Then re-present both → req0 wins again.
- Back-pressure: rsp_ready_in=0 for 5 cycles after rsp_valid_out rises → rsp_data/id held stable, both ready_out stay 0, busy_out=1. Release → IDLE next cycle.
- Reset mid-op: deassert rst_n_in while in ISSUE → all outputs 0 immediately. After release, the first contended request goes to req0 and no stale response appears.
- Opcode check with ALU_ARB_OPCHECK_EN defined: opcode 0xF → rsp_valid_out at N+1, data 0, err 1, alu_opcode_out unchanged. Without the macro: same stimulus → response at N+2, err 0.
